// File: rtl/tile_generator_pkg.sv
// Shared types and constants for the tile piece source.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package tile_generator_pkg;

    // eNon marks "no piece"; codes 1..7 are real pieces.
    typedef enum logic [2:0] {
        eNon = 3'd0,
        eI   = 3'd1,
        eJ   = 3'd2,
        eL   = 3'd3,
        eO   = 3'd4,
        eS   = 3'd5,
        eT   = 3'd6,
        eZ   = 3'd7
    } tile_type_e;

    localparam int TILE_COUNT = 7;

    // Feedback taps on bits 15, 13, 12 and 10 (maximal-length 16-bit sequence).
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        eSeed = 2'd0,
        eDraw = 2'd1,
        eFull = 2'd2
    } gen_state_e;

endpackage

// File: rtl/tile_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR (shift left, feedback into bit 0).
// Latency: new value every cycle, seed loaded on the reset edge.
// Backpressure: none; it never stalls.
// Ports: clk_i clock, reset_i sync active-high reset, state_o current LFSR state.
module tile_lfsr16
    import tile_generator_pkg::*;
#(
    parameter logic [15:0] seed_p = 16'hACE1
) (
    input  logic        clk_i,
    input  logic        reset_i,
    output logic [15:0] state_o
);

    // The all-zero state is a lock-up point, so a zero seed is promoted to 1.
    localparam logic [15:0] seed_lp = (seed_p == 16'h0000) ? 16'h0001 : seed_p;

    logic [15:0] state_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= seed_lp;
        end else begin
            state_q <= {state_q[14:0], ^(state_q & LFSR_TAPS)};
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/tile_generator.sv
// 7-bag piece generator feeding a small preview queue; head offered via valid/yumi.
// Latency: first piece valid 2 cycles after reset/flush release, queue full after depth_p+1.
// Backpressure: stops drawing while the queue is full; each yumi frees one slot for refill.
// Ports: clk_i, reset_i (sync, active-high), flush_i (new game), yumi_i (take head);
//        v_o/tile_type_o/tile_type_angle_o = head, next_v_o/next_tile_o = entry behind head.
// Build option: TILE_GENERATOR_RANDOM_ANGLE_EN stores a random 2-bit angle per entry;
//        without it the angle output is tied to 0.
module tile_generator
    import tile_generator_pkg::*;
#(
    parameter int          depth_p = 4,
    parameter logic [15:0] seed_p  = 16'hACE1
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       flush_i,
    output tile_type_e tile_type_o,
    output logic [1:0] tile_type_angle_o,
    output logic       v_o,
    input  logic       yumi_i,
    output tile_type_e next_tile_o,
    output logic       next_v_o
);

    localparam int ptr_w_lp = $clog2(depth_p);
    localparam int cnt_w_lp = $clog2(depth_p + 1);

    logic [15:0]         lfsr;
    gen_state_e          state_q, state_d;
    logic [6:0]          bag_r, bag_d, bag_left, bag_after;
    logic [cnt_w_lp-1:0] count_q, count_d;
    logic [ptr_w_lp-1:0] rd_q, wr_q, rd_next;
    logic                push, pop;
    logic [2:0]          c0, pick_idx, idx;
    logic                found;
    tile_type_e          pick;
    tile_type_e          type_mem [depth_p];
    logic                unused_lfsr;

    tile_lfsr16 #(.seed_p(seed_p)) u_lfsr (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .state_o (lfsr)
    );

    assign unused_lfsr = ^lfsr[15:3];

    function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
        return (p == ptr_w_lp'(depth_p - 1)) ? '0 : p + ptr_w_lp'(1);
    endfunction

    // Bag draw: scan upward from the LFSR-chosen start code, wrapping 7->1,
    // and take the first code still present in the bag.
    assign c0 = (lfsr[2:0] == 3'd0) ? 3'd1 : lfsr[2:0];

    always_comb begin
        found    = 1'b0;
        pick_idx = '0;
        idx      = '0;
        for (int k = 0; k < TILE_COUNT; k++) begin
            idx = 3'((int'(c0) - 1 + k) % TILE_COUNT);
            if (!found && bag_r[idx]) begin
                found    = 1'b1;
                pick_idx = idx;
            end
        end
        pick      = tile_type_e'(pick_idx + 3'd1);
        bag_left  = bag_r & ~(7'b1 << pick_idx);
        // Emptying the bag refills it in the same update so the next draw never stalls.
        bag_after = (bag_left == 7'h00) ? 7'h7F : bag_left;
    end

    always_comb begin
        state_d = state_q;
        bag_d   = bag_r;
        push    = 1'b0;
        pop     = 1'b0;
        case (state_q)
            eSeed: begin
                bag_d   = 7'h7F;
                state_d = eDraw;
            end
            eDraw: begin
                push  = 1'b1;
                pop   = yumi_i && (count_q != '0);
                bag_d = bag_after;
            end
            eFull: begin
                pop = yumi_i && (count_q != '0);
                if (pop) state_d = eDraw;
            end
            default: state_d = eSeed;
        endcase
        // Flush outranks any push or pop in the same cycle.
        if (flush_i) begin
            push    = 1'b0;
            pop     = 1'b0;
            state_d = eSeed;
        end
        count_d = count_q + cnt_w_lp'(push) - cnt_w_lp'(pop);
        if (state_q == eDraw && !flush_i && count_d == cnt_w_lp'(depth_p)) begin
            state_d = eFull;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i || flush_i) begin
            state_q <= eSeed;
            bag_r   <= 7'h7F;
            count_q <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
        end else begin
            state_q <= state_d;
            bag_r   <= bag_d;
            count_q <= count_d;
            if (push) wr_q <= ptr_inc(wr_q);
            if (pop)  rd_q <= ptr_inc(rd_q);
        end
    end

    // Storage needs no reset: every read is qualified by count_q.
    always_ff @(posedge clk_i) begin
        if (push && !reset_i) begin
            type_mem[wr_q] <= pick;
        end
    end

    assign rd_next     = ptr_inc(rd_q);
    assign v_o         = (count_q != '0);
    assign next_v_o    = (count_q >= cnt_w_lp'(2));
    assign tile_type_o = v_o ? type_mem[rd_q] : eNon;
    assign next_tile_o = next_v_o ? type_mem[rd_next] : eNon;

`ifdef TILE_GENERATOR_RANDOM_ANGLE_EN
    logic [1:0] angle_mem [depth_p];

    always_ff @(posedge clk_i) begin
        if (push && !reset_i) begin
            angle_mem[wr_q] <= lfsr[4:3];
        end
    end

    assign tile_type_angle_o = v_o ? angle_mem[rd_q] : 2'b00;
`else
    assign tile_type_angle_o = 2'b00;
`endif

endmodule

// File: doc/tile_generator.md
Name: tile_generator

Overview:
- Upstream piece source for the tile executor.
- Produces a stream of tile types using a 7-bag randomiser driven by a free-running 16-bit LFSR.
- Buffers upcoming pieces in a small preview queue and presents the head with a valid/yumi handshake. The integrator drives yumi_i from the executor accepting v_i in its idle state.
- Exposes the next piece for a "next" display.

Parameters:
- depth_p, 4, queue entries (head + depth_p-1 previews); legal range 2..8.
- seed_p, 16'hACE1, LFSR reset value; 0 is replaced by 16'h0001.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous, active-high reset
- flush_i  in  1  new game: discard queue and bag, refill
- tile_type_o  out  tile_type_e (3)  head piece type
- tile_type_angle_o  out  2  head piece initial angle
- v_o  out  1  head valid
- yumi_i  in  1  consumer takes head this cycle; legal only when v_o=1
- next_tile_o  out  tile_type_e (3)  entry behind head; eNon if absent
- next_v_o  out  1  next_tile_o valid

Behaviour:
- Encoding: tile_type_e is 3 bits, eNon=0, piece codes 1..7. bag_r bit (c-1) set means code c is still available in the current bag.
- LFSR: Fibonacci, shift left, bit0 <= l[15]^l[13]^l[12]^l[10]. Advances every cycle including reset-release cycles. Reset loads seed_p. flush_i does not reseed.
- FSM states:
  - eSeed: bag_r<=7'h7F, count<=0 -> eDraw next cycle.
  - eDraw: push one piece per cycle while count<depth_p -> eFull when the push makes count==depth_p.
  - eFull: no push; on yumi_i -> eDraw.
- Draw rule (combinational, one per cycle):
  - c0 = (l[2:0]==0) ? 1 : l[2:0].
  - Pick the first code c scanning c0, c0+1, ... wrapping 7->1 with bag bit set. Push c and clear its bit.
  - If the bag becomes empty, bag_r<=7'h7F in the same update.
  - Every aligned group of 7 pushes after eSeed is therefore a permutation of 1..7.
- Queue: circular FIFO with rd/wr pointers and a count of $clog2(depth_p+1) bits.
  - Push and pop in the same cycle are both honoured; count is unchanged.
  - A pop may occur in eDraw or eFull. A pop in eFull re-enters eDraw, and the next push lands the following cycle.
- Outputs, all registered from queue state:
  - v_o = count!=0. tile_type_o/tile_type_angle_o = head entry, else eNon/0.
  - next_v_o = count>=2. next_tile_o = entry rd+1, else eNon.
  - Head fields hold stable while v_o=1 and no yumi_i.
- yumi_i with v_o=0 is ignored (no pointer movement). The bench flags it as an error.
- Latency: reset/flush deasserted at edge k gives eSeed in cycle k, first push at edge k+2, v_o=1 after edge k+2. The queue is full after edge k+1+depth_p.
- flush_i: synchronous, same effect as reset except the LFSR keeps running. It has priority over yumi_i and push in the same cycle. Outputs go to v_o=0/eNon/0 next cycle.
- Reset values: v_o=0, next_v_o=0, tile_type_o=eNon, next_tile_o=eNon, tile_type_angle_o=0, state eSeed, lfsr=seed_p.
- reset_i mid-operation: same as above on the next edge; no partial state survives.

Optional Feature:
- Macro: TILE_GENERATOR_RANDOM_ANGLE_EN.
- Defined: each pushed entry stores angle l[4:3] sampled in its push cycle; the queue carries a 2-bit angle per entry.
- Undefined: angle storage is removed and tile_type_angle_o is constant 0.
- All other behaviour is identical in both builds.

Decomposition:
- The tetris package holds:
  - tile_type_e (if not already present);
  - constants TILE_COUNT=7 and LFSR_TAPS;
  - the generator state enum (eSeed, eDraw, eFull).
- One sub-module: tile_lfsr16, with clk_i, reset_i, a seed parameter, and 16-bit state output. It is reusable by other randomised blocks.
- Bag selection and the queue stay inline.

Test Plan:
- Reset, seed_p=16'hACE1, no yumi -> v_o=1 after edge 2. count reaches 4 after edge 5, then state holds eFull. Entries match a golden model of the LFSR and draw rule.
- yumi_i on every cycle v_o=1 for 70 pops -> each group of 7 consecutive types is a permutation of 1..7; no eNon ever popped.
- Queue full, single yumi_i -> head advances to the previous next_tile_o in 1 cycle. The refill push lands 2 cycles after yumi; count returns to depth_p.
- flush_i together with yumi_i while full -> next cycle v_o=0, tile_type_o=eNon, next_v_o=0. v_o=1 again 2 cycles after flush deasserts; the sequence differs from post-reset because the LFSR was not reseeded.
- seed_p=0 -> behaves exactly as seed_p=16'h0001. The LFSR never reaches all-zero over 65535 cycles.
- Build with and without TILE_GENERATOR_RANDOM_ANGLE_EN:
  - defined: angle equals l[4:3] of the push cycle;
  - undefined: angle always 0;
  - identical type sequence in both builds.
